// File: rtl/sw_debounce_sync.sv
// Slide-switch conditioner: multi-flop synchronizer followed by a whole-vector
// debounce filter that commits a new value only after it holds steady.
module sw_debounce_sync #(
  parameter int WIDTH           = 18,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  localparam int NDIG           = (WIDTH + 3) / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_stable,
  output logic             update,
  output logic [NDIG-1:0]  digit_mask
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PADW = NDIG * 4;
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t                             state;
  logic [CW-1:0]                      cnt;
  logic [WIDTH-1:0]                   candidate;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]  sync_ff;
  logic [WIDTH-1:0]                   sync_q;
  logic [PADW-1:0]                    diff_pad;
  logic [NDIG-1:0]                    mask_next;

  // sw_in is asynchronous; only the first synchronizer stage may sample it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], sw_in};
    end
  end

  assign sync_q = sync_ff[SYNC_STAGES-1];

  // A partial top nibble is zero-padded so it still reports its own change.
  always_comb begin
    diff_pad             = '0;
    diff_pad[WIDTH-1:0]  = candidate ^ sw_stable;
    mask_next            = '0;
    for (int i = 0; i < NDIG; i++) begin
      mask_next[i] = |diff_pad[i*4 +: 4];
    end
  end

  // update is a one-cycle strobe with no back-pressure: the consumer must
  // take sw_stable/digit_mask on the cycle update is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      candidate  <= '0;
      sw_stable  <= '0;
      update     <= 1'b0;
      digit_mask <= '0;
    end else begin
      update     <= 1'b0;
      digit_mask <= '0;
      case (state)
        IDLE: begin
          if (sync_q != sw_stable) begin
            candidate <= sync_q;
            cnt       <= CNT_ONE;
            state     <= COUNT;
          end
        end
        COUNT: begin
          if (sync_q == sw_stable) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (sync_q != candidate) begin
            candidate <= sync_q;
            cnt       <= CNT_ONE;
          end else if (cnt == CNT_DONE) begin
            sw_stable  <= candidate;
            update     <= 1'b1;
            digit_mask <= mask_next;
            cnt        <= '0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
